// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART frame transmitter among N_REQ byte producers.
// Frames are paced by a fixed guard timer because the transmitter reports no completion.
`timescale 1ns / 1ps

module uart_tx_sched #(
  parameter int N_REQ        = 4,
  parameter int FRAME_CYCLES = 16
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [N_REQ-1:0]                         req,
  input  logic [8*N_REQ-1:0]                       req_data,
  output logic [N_REQ-1:0]                         ack,
  output logic                                     send,
  output logic [7:0]                               data,
  output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] grant_id,
  output logic                                     busy,
  output logic [15:0]                              frames_sent
);

  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW  = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [IDW-1:0]   last_reg, last_next;
  logic [N_REQ-1:0] ack_reg, ack_next;
  logic             send_reg, send_next;
  logic [7:0]       data_reg, data_next;
  logic [IDW-1:0]   grant_reg, grant_next;
  logic             busy_reg, busy_next;
  logic [15:0]      frames_reg, frames_next;

  logic [7:0]       req_bytes [N_REQ];
  logic [N_REQ-1:0] above_last;
  logic [N_REQ-1:0] masked_req;
  logic [N_REQ-1:0] pick_src;
  logic [IDW-1:0]   winner;
  logic             has_req;

  // above_last marks the requesters that come after the last winner in rotation order.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign req_bytes[gi]  = req_data[8*gi +: 8];
      assign above_last[gi] = (gi > int'(last_reg));
    end
  endgenerate

  // Lowest set bit above the last winner; if none, wrap to the lowest set bit overall.
  always_comb begin
    masked_req = req & above_last;
    pick_src   = (|masked_req) ? masked_req : req;
    has_req    = |req;
    winner     = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (pick_src[i]) begin
        winner = IDW'(i);
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    last_next   = last_reg;
    ack_next    = '0;
    send_next   = 1'b0;
    data_next   = data_reg;
    grant_next  = grant_reg;
    busy_next   = busy_reg;
    frames_next = frames_reg;
    case (state_reg)
      IDLE: begin
        if (has_req) begin
          ack_next[winner] = 1'b1;
          send_next        = 1'b1;
          data_next        = req_bytes[winner];
          grant_next       = winner;
          last_next        = winner;
          frames_next      = frames_reg + 16'd1;
          cnt_next         = CW'(FRAME_CYCLES - 1);
          busy_next        = 1'b1;
          state_next       = WAIT;
        end
      end
      WAIT: begin
        if (cnt_reg == '0) begin
          busy_next  = 1'b0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      last_reg   <= IDW'(N_REQ - 1);
      ack_reg    <= '0;
      send_reg   <= 1'b0;
      data_reg   <= 8'h00;
      grant_reg  <= '0;
      busy_reg   <= 1'b0;
      frames_reg <= 16'h0000;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      last_reg   <= last_next;
      ack_reg    <= ack_next;
      send_reg   <= send_next;
      data_reg   <= data_next;
      grant_reg  <= grant_next;
      busy_reg   <= busy_next;
      frames_reg <= frames_next;
    end
  end

  assign ack         = ack_reg;
  assign send        = send_reg;
  assign data        = data_reg;
  assign grant_id    = grant_reg;
  assign busy        = busy_reg;
  assign frames_sent = frames_reg;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: directed scenarios plus randomized traffic
// compared against a rotation-order model of grants and a send-time model.
`timescale 1ns / 1ps

module tb_uart_tx_sched;

  localparam int N      = 4;
  localparam int FC     = 16;
  localparam int PERIOD = 10;

  logic           clk      = 1'b0;
  logic           rst      = 1'b1;
  logic [N-1:0]   req      = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   ack;
  logic           send;
  logic [7:0]     data;
  logic [1:0]     grant_id;
  logic           busy;
  logic [15:0]    frames_sent;

  int  vectors    = 0;
  int  miscompares = 0;
  int  m_last     = N - 1;
  int  m_frames   = 0;
  time t_prev     = 0;

  uart_tx_sched #(.N_REQ(N), .FRAME_CYCLES(FC)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .send        (send),
    .data        (data),
    .grant_id    (grant_id),
    .busy        (busy),
    .frames_sent (frames_sent)
  );

  always #(PERIOD / 2) clk = ~clk;

  initial begin
    #(100000 * PERIOD);
    $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // Next owner in rotation: first requesting index after the previous winner, modulo N.
  function automatic int pick(input logic [N-1:0] r, input int last);
    int idx;
    for (int k = 1; k <= N; k++) begin
      idx = (last + k) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic wait_send(input int limit, output int n);
    n = 0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (send === 1'b1) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic wait_idle(input int limit, output int n);
    n = 0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic test_reset;
    rst      = 1'b1;
    req      = '1;
    req_data = $urandom;
    repeat (3) @(negedge clk);
    vectors++;
    if (ack !== '0 || send !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_with_req: ack=%b send=%b, expected ack=0000 send=0", ack, send);
    end
    vectors++;
    if (data !== 8'h00 || grant_id !== 2'd0 || busy !== 1'b0 || frames_sent !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_values: data=%h grant_id=%0d busy=%b frames=%h, expected all zero",
               data, grant_id, busy, frames_sent);
    end
    req = '0;
    @(negedge clk);
    rst      = 1'b0;
    m_last   = N - 1;
    m_frames = 0;
    @(negedge clk);
  endtask

  task automatic test_single;
    int n;
    req_data        = $urandom;
    req_data[23:16] = 8'hA5;
    req             = 4'b0100;
    wait_send(4, n);
    vectors++;
    if (n !== 1) begin
      miscompares++;
      $display("FAIL single_latency: send after %0d cycles, expected 1", n);
    end
    vectors++;
    if (ack !== 4'b0100 || data !== 8'hA5 || grant_id !== 2'd2 || busy !== 1'b1
        || frames_sent !== 16'd1) begin
      miscompares++;
      $display("FAIL single_grant: ack=%b data=%h gid=%0d busy=%b frames=%0d, expected 0100 a5 2 1 1",
               ack, data, grant_id, busy, frames_sent);
    end
    m_last = 2;
    m_frames++;
    t_prev = $time;
    req    = '0;
    for (int i = 2; i <= FC; i++) begin
      @(negedge clk);
      vectors++;
      if (busy !== 1'b1 || send !== 1'b0 || ack !== '0 || data !== 8'hA5) begin
        miscompares++;
        $display("FAIL single_wait_cycle%0d: busy=%b send=%b ack=%b data=%h, expected 1 0 0000 a5",
                 i, busy, send, ack, data);
      end
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_busy_end: busy=%b after %0d cycles, expected 0", busy, FC);
    end
  endtask

  task automatic test_contention;
    int n;
    int w;
    rst = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    m_last   = N - 1;
    m_frames = 0;
    req_data = $urandom;
    req      = '1;
    for (int g = 0; g < 8; g++) begin
      wait_send(2 * FC + 4, n);
      vectors++;
      if (n == 0) begin
        miscompares++;
        $display("FAIL contention_timeout: no send for grant %0d, expected one", g);
        continue;
      end
      w = g % N;
      vectors++;
      if (grant_id !== 2'(w) || ack !== N'(1 << w) || data !== req_data[8*w +: 8]
          || frames_sent !== 16'(m_frames + 1)) begin
        miscompares++;
        $display("FAIL contention_grant%0d: gid=%0d ack=%b data=%h frames=%0d, expected %0d %b %h %0d",
                 g, grant_id, ack, data, frames_sent, w, N'(1 << w), req_data[8*w +: 8], m_frames + 1);
      end
      if (g > 0) begin
        vectors++;
        if (($time - t_prev) != (FC + 1) * PERIOD) begin
          miscompares++;
          $display("FAIL contention_spacing%0d: %0d cycles, expected %0d",
                   g, ($time - t_prev) / PERIOD, FC + 1);
        end
      end
      m_last = w;
      m_frames++;
      t_prev = $time;
      req_data[8*w +: 8] = 8'($urandom);
    end
  endtask

  task automatic test_wrap_skip;
    int n;
    int exp_w [3] = '{1, 3, 1};
    req = 4'b1010;
    for (int g = 0; g < 3; g++) begin
      wait_send(2 * FC + 4, n);
      vectors++;
      if (n == 0) begin
        miscompares++;
        $display("FAIL wrap_timeout: no send for grant %0d, expected one", g);
        continue;
      end
      vectors++;
      if (grant_id !== 2'(exp_w[g]) || ack !== N'(1 << exp_w[g])
          || data !== req_data[8*exp_w[g] +: 8] || frames_sent !== 16'(m_frames + 1)
          || ($time - t_prev) != (FC + 1) * PERIOD) begin
        miscompares++;
        $display("FAIL wrap_grant%0d: gid=%0d ack=%b data=%h frames=%0d gap=%0d, expected %0d %b %h %0d %0d",
                 g, grant_id, ack, data, frames_sent, ($time - t_prev) / PERIOD, exp_w[g],
                 N'(1 << exp_w[g]), req_data[8*exp_w[g] +: 8], m_frames + 1, FC + 1);
      end
      m_last = exp_w[g];
      m_frames++;
      t_prev = $time;
      req_data[8*exp_w[g] +: 8] = 8'($urandom);
    end
    req = '0;
  endtask

  task automatic test_wait_req;
    int n;
    int w;
    logic [7:0] held;
    wait_idle(2 * FC + 4, n);
    vectors++;
    if (n == 0) begin
      miscompares++;
      $display("FAIL waitreq_idle_timeout: busy=%b, expected 0", busy);
    end
    req_data = $urandom;
    req      = 4'b0010;
    wait_send(4, n);
    w    = pick(4'b0010, m_last);
    held = req_data[15:8];
    vectors++;
    if (n !== 1 || grant_id !== 2'(w) || data !== held) begin
      miscompares++;
      $display("FAIL waitreq_first: latency=%0d gid=%0d data=%h, expected 1 %0d %h",
               n, grant_id, data, w, held);
    end
    m_last = w;
    m_frames++;
    t_prev = $time;
    req    = '0;
    repeat (4) begin
      @(negedge clk);
      vectors++;
      if (ack !== '0 || send !== 1'b0 || data !== held) begin
        miscompares++;
        $display("FAIL waitreq_early: ack=%b send=%b data=%h, expected 0000 0 %h", ack, send, data, held);
      end
    end
    req             = 4'b0001;
    req_data[7:0]   = 8'($urandom);
    req_data[15:8]  = ~held;
    repeat (FC - 4) begin
      @(negedge clk);
      vectors++;
      if (ack !== '0 || send !== 1'b0 || data !== held) begin
        miscompares++;
        $display("FAIL waitreq_ignored: ack=%b send=%b data=%h, expected 0000 0 %h", ack, send, data, held);
      end
    end
    wait_send(1, n);
    vectors++;
    if (n !== 1 || grant_id !== 2'd0 || ack !== 4'b0001 || data !== req_data[7:0]
        || ($time - t_prev) != (FC + 1) * PERIOD) begin
      miscompares++;
      $display("FAIL waitreq_grant: seen=%0d gid=%0d ack=%b data=%h gap=%0d, expected 1 0 0001 %h %0d",
               n, grant_id, ack, data, ($time - t_prev) / PERIOD, req_data[7:0], FC + 1);
    end
    m_last = 0;
    m_frames++;
    t_prev = $time;
    req    = '0;
  endtask

  task automatic test_reset_mid;
    int n;
    int w;
    wait_idle(2 * FC + 4, n);
    req_data = $urandom;
    req      = '1;
    wait_send(4, n);
    w = pick('1, m_last);
    vectors++;
    if (n !== 1 || grant_id !== 2'(w)) begin
      miscompares++;
      $display("FAIL resetmid_grant: latency=%0d gid=%0d, expected 1 %0d", n, grant_id, w);
    end
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || send !== 1'b0 || data !== 8'h00 || frames_sent !== 16'h0000
        || ack !== '0 || grant_id !== 2'd0) begin
      miscompares++;
      $display("FAIL resetmid_values: busy=%b send=%b data=%h frames=%0d ack=%b gid=%0d, expected all zero",
               busy, send, data, frames_sent, ack, grant_id);
    end
    rst      = 1'b0;
    m_last   = N - 1;
    m_frames = 0;
    wait_send(4, n);
    vectors++;
    if (n !== 1 || grant_id !== 2'd0 || ack !== 4'b0001 || data !== req_data[7:0]
        || frames_sent !== 16'd1) begin
      miscompares++;
      $display("FAIL resetmid_after: latency=%0d gid=%0d ack=%b data=%h frames=%0d, expected 1 0 0001 %h 1",
               n, grant_id, ack, data, frames_sent, req_data[7:0]);
    end
    m_last = 0;
    m_frames++;
    t_prev = $time;
    req    = '0;
  endtask

  task automatic test_random;
    int  n;
    int  w;
    int  k;
    time t_set;
    time t_exp;
    for (int it = 0; it < 30; it++) begin
      req_data = $urandom;
      req      = N'($urandom_range(1, (1 << N) - 1));
      t_set    = $time;
      k        = $urandom_range(1, 3);
      for (int j = 0; j < k; j++) begin
        wait_send(2 * FC + 4, n);
        vectors++;
        if (n == 0) begin
          miscompares++;
          $display("FAIL random_timeout: iteration %0d req=%b, expected a send", it, req);
          break;
        end
        w     = pick(req, m_last);
        t_exp = t_prev + (FC + 1) * PERIOD;
        if (t_set + PERIOD > t_exp) t_exp = t_set + PERIOD;
        vectors++;
        if (grant_id !== 2'(w) || ack !== N'(1 << w) || data !== req_data[8*w +: 8]
            || frames_sent !== 16'(m_frames + 1) || $time != t_exp) begin
          miscompares++;
          $display("FAIL random_grant%0d.%0d: req=%b gid=%0d ack=%b data=%h frames=%0d t=%0t, expected %0d %b %h %0d t=%0t",
                   it, j, req, grant_id, ack, data, frames_sent, $time, w, N'(1 << w),
                   req_data[8*w +: 8], m_frames + 1, t_exp);
        end
        m_last = w;
        m_frames++;
        t_prev = $time;
        req_data[8*w +: 8] = 8'($urandom);
      end
      req = '0;
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_wrap_skip();
    test_wait_req();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
